alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the operand width; the result is DATA_W+1 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 wants an operation.
REQ-005 The block SHALL have port op0, input, 2 bits: requester 0 opcode (00 add, 01 sub, 10 and, 11 or).
REQ-006 The block SHALL have ports a0 and b0, input, DATA_W bits each: requester 0 operands.
REQ-007 The block SHALL have ports req1, op1, a1 and b1 (input; 1, 2, DATA_W and DATA_W bits): requester 1 equivalents of REQ-004 to REQ-006.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: the requester currently owns the ALU.
REQ-009 The block SHALL have ports done0 and done1, output, 1 bit each: one-cycle result-valid pulse to the owner.
REQ-010 The block SHALL have port result, output, DATA_W+1 bits: registered ALU result, shared by both requesters.
REQ-011 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-012 The block SHALL have ports alu_sel (2 bits), alu_a and alu_b (DATA_W bits each), all outputs: drive the external ALU.
REQ-013 The block SHALL have port alu_out, input, DATA_W+1 bits: external ALU combinational result.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, EXEC and WB.
REQ-015 In IDLE with any req high, the block SHALL select a winner, latch its op and operands, assert its gnt and go to EXEC on the next edge.
REQ-016 In EXEC, the block SHALL drive the latched op/operands on alu_sel/alu_a/alu_b, capture alu_out into result and go to WB.
REQ-017 In WB, the block SHALL pulse the owner's done for exactly one cycle, then drop gnt and return to IDLE.
REQ-018 Latency: a req first seen high at edge N SHALL produce done high during the cycle after edge N+2; throughput is one operation per 3 cycles.
REQ-019 Requesters hold req until done; a req still high in the cycle after done SHALL count as a new request.
REQ-020 Operands SHALL be sampled only at the IDLE->EXEC edge; later changes to a*/b*/op* SHALL have no effect on the current operation.
REQ-021 Tie rule (default): when both req are high in IDLE, the block SHALL grant the requester not served last (round-robin pointer).
REQ-022 The round-robin pointer SHALL update only on a grant.
REQ-023 A single active requester SHALL always win, regardless of the pointer.
REQ-024 result SHALL hold its value until the next EXEC capture.
REQ-025 At most one gnt and at most one done SHALL be high at any time.
REQ-026 alu_sel/alu_a/alu_b SHALL be 0 in IDLE.
REQ-027 The block SHALL treat alu_out as full-width arithmetic: sub borrow appears in bit DATA_W; bit DATA_W is 0 for and/or.

Reset
REQ-028 While rst is high, the FSM SHALL be in IDLE, with gnt*, done*, busy, result, alu_* and all latched operands at 0.
REQ-029 While rst is high, the round-robin pointer SHALL favour requester 0 on the first tie.
REQ-030 rst asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 After reset, a requester whose operation was aborted SHALL be treated as a new request if its req is still high.

Configuration
REQ-032 If macro ALU_ARB_FIXED_PRIO_EN is defined, requester 0 SHALL always win ties and the pointer logic SHALL be omitted.
REQ-033 If ALU_ARB_FIXED_PRIO_EN is undefined, the round-robin rule of REQ-021 SHALL apply.

Verification
REQ-034 Scenario: after reset, req0=1, op0=00, a0=0xFF, b0=0x01 -> gnt0 next cycle; done0 two cycles later with result=0x100.
REQ-035 Scenario: req1=1, op1=01, a1=0x05, b1=0x07 -> done1 with result=0x1FE.
REQ-036 Scenario: req0 and req1 both held high continuously -> grant order 0,1,0,1; done pulses 3 cycles apart (with ALU_ARB_FIXED_PRIO_EN: 0,0,0).
REQ-037 Scenario: change a0 during EXEC -> result reflects the operands latched at grant.
REQ-038 Scenario: rst pulsed during EXEC -> no done, all outputs 0; req0 still high -> new grant after reset release.
REQ-039 Scenario: op=10 with a=0xF0, b=0x3C -> result=0x030; op=11 with the same operands -> result=0x0FC.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the shared external ALU and the
// alu_arbiter. The arbiter uses the slave view; whoever models the requesters
// and the ALU uses the master view.
interface alu_arbiter_if #(
  parameter int DATA_W = 8
);
  // Requester 0
  logic              req0;
  logic [1:0]        op0;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  // Requester 1
  logic              req1;
  logic [1:0]        op1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  // Ownership and completion back to the requesters
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W:0]   result;
  logic              busy;
  // External ALU
  logic [1:0]        alu_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   alu_out;

  modport slave (
    input  req0, op0, a0, b0,
    input  req1, op1, a1, b1,
    input  alu_out,
    output gnt0, gnt1, done0, done1, result, busy,
    output alu_sel, alu_a, alu_b
  );

  modport master (
    output req0, op0, a0, b0,
    output req1, op1, a1, b1,
    output alu_out,
    input  gnt0, gnt1, done0, done1, result, busy,
    input  alu_sel, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared external combinational ALU.
// IDLE picks a winner and latches its opcode/operands, EXEC drives the ALU and
// captures its output, WB finishes so that done pulses in the following cycle.
// Ties go round-robin by default; define ALU_ARB_FIXED_PRIO_EN to make
// requester 0 always win ties (the round-robin pointer is then left out).
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W:0]   result_q, result_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              any_req;
  logic              win;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // prio_q names the requester favoured on the next tie (0 out of reset)
  logic              prio_q, prio_d;
`endif

  assign any_req = bus.req0 | bus.req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks; requester 1 only when alone
  always_comb begin
    win = ~bus.req0;
  end
`else
  // A lone requester always wins; on a tie the favoured requester wins
  always_comb begin
    if (bus.req0 && bus.req1) begin
      win = prio_q;
    end else begin
      win = bus.req1;
    end
  end
`endif

  // Next-state logic: grant and latch in IDLE, capture in EXEC, raise done in WB
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    prio_d   = prio_q;
`endif
    case (state_q)
      IDLE: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (any_req) begin
          state_d = EXEC;
          owner_d = win;
          op_d    = win ? bus.op1 : bus.op0;
          a_d     = win ? bus.a1  : bus.a0;
          b_d     = win ? bus.b1  : bus.b0;
          gnt0_d  = ~win;
          gnt1_d  = win;
`ifndef ALU_ARB_FIXED_PRIO_EN
          prio_d  = ~win;
`endif
        end
      end
      EXEC: begin
        result_d = bus.alu_out;
        state_d  = WB;
      end
      WB: begin
        done0_d = ~owner_q;
        done1_d = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight and clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves only when a grant is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  // The ALU sees the latched operation only during EXEC and zeros otherwise
  always_comb begin
    bus.alu_sel = '0;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    if (state_q == EXEC) begin
      bus.alu_sel = op_q;
      bus.alu_a   = a_q;
      bus.alu_b   = b_q;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter. The bench plays both
// requesters and the external ALU; expected values are hand-computed constants.
module tb_alu_arbiter;

  localparam int DATA_W = 8;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  alu_arbiter_if #(.DATA_W(DATA_W)) bus ();

  alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External ALU: full-width add/sub, bit DATA_W is 0 for and/or
  always_comb begin
    case (bus.alu_sel)
      2'b00:   bus.alu_out = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'b01:   bus.alu_out = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      2'b10:   bus.alu_out = {1'b0, bus.alu_a & bus.alu_b};
      default: bus.alu_out = {1'b0, bus.alu_a | bus.alu_b};
    endcase
  end

  // Advance to just after the next rising edge, where outputs are stable
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one requester's request lines
  task automatic applyStimulus(input int which, input logic req, input logic [1:0] op,
                               input logic [7:0] a, input logic [7:0] b);
    if (which == 0) begin
      bus.req0 = req; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = req; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
  endtask

  // Every output must read zero (reset or quiet idle)
  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".gnt"},    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    checkOutput({tag, ".done"},   {30'd0, bus.done1, bus.done0}, 32'd0);
    checkOutput({tag, ".busy"},   {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, ".result"}, {23'd0, bus.result}, 32'd0);
    checkOutput({tag, ".alu"},    {14'd0, bus.alu_sel, bus.alu_a, bus.alu_b}, 32'd0);
  endtask

  // One isolated operation from an idle arbiter, checking the full timeline
  task automatic runOp(input string tag, input int which, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic [8:0] expRes);
    logic [1:0] ownGnt;
    ownGnt = (which == 0) ? 2'b01 : 2'b10;
    applyStimulus(which, 1'b1, op, a, b);
    tick();
    checkOutput({tag, ".gnt"},  {30'd0, bus.gnt1, bus.gnt0}, {30'd0, ownGnt});
    checkOutput({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
    checkOutput({tag, ".alu"},  {14'd0, bus.alu_sel, bus.alu_a, bus.alu_b}, {14'd0, op, a, b});
    tick();
    checkOutput({tag, ".done_early"}, {30'd0, bus.done1, bus.done0}, 32'd0);
    checkOutput({tag, ".result_wb"},  {23'd0, bus.result}, {23'd0, expRes});
    tick();
    checkOutput({tag, ".done"},   {30'd0, bus.done1, bus.done0}, {30'd0, ownGnt});
    checkOutput({tag, ".result"}, {23'd0, bus.result}, {23'd0, expRes});
    applyStimulus(which, 1'b0, op, a, b);
    tick();
    checkOutput({tag, ".done_end"}, {30'd0, bus.done1, bus.done0}, 32'd0);
    checkOutput({tag, ".idle"},     {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, ".result_hold"}, {23'd0, bus.result}, {23'd0, expRes});
  endtask

  initial begin
    int owner [3];
    int own;
    logic [8:0] expRes;

    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    applyStimulus(0, 1'b0, 2'b00, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    // add with carry out, then sub with borrow, then and/or
    runOp("add0", 0, 2'b00, 8'hFF, 8'h01, 9'h100);
    runOp("sub1", 1, 2'b01, 8'h05, 8'h07, 9'h1FE);
    runOp("and0", 0, 2'b10, 8'hF0, 8'h3C, 9'h030);
    runOp("or1",  1, 2'b11, 8'hF0, 8'h3C, 9'h0FC);

    // Operand changes after the grant must not affect the running operation
    applyStimulus(0, 1'b1, 2'b00, 8'h10, 8'h20);
    tick();
    applyStimulus(0, 1'b1, 2'b01, 8'h55, 8'h66);
    checkOutput("latch.alu", {14'd0, bus.alu_sel, bus.alu_a, bus.alu_b}, {14'd0, 2'b00, 8'h10, 8'h20});
    tick();
    tick();
    checkOutput("latch.done",   {30'd0, bus.done1, bus.done0}, 32'd1);
    checkOutput("latch.result", {23'd0, bus.result}, 32'h030);
    applyStimulus(0, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();

    // Reset in EXEC aborts without done; a held req is re-granted afterwards
    applyStimulus(0, 1'b1, 2'b00, 8'h01, 8'h02);
    tick();
    checkOutput("abort.gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    rst = 1'b1;
    #1;
    checkAllZero("abort.async");
    tick();
    checkAllZero("abort.held");
    rst = 1'b0;
    tick();
    checkOutput("abort.regnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    tick();
    tick();
    checkOutput("abort.done",   {30'd0, bus.done1, bus.done0}, 32'd1);
    checkOutput("abort.result", {23'd0, bus.result}, 32'h003);
    applyStimulus(0, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();

    // Both requesters held: pointer starts favouring 0 after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    owner[0] = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    owner[1] = 0;
`else
    owner[1] = 1;
`endif
    owner[2] = 0;
    applyStimulus(0, 1'b1, 2'b00, 8'h03, 8'h04);
    applyStimulus(1, 1'b1, 2'b10, 8'h0F, 8'h3C);
    for (int k = 1; k <= 9; k++) begin
      tick();
      own    = owner[(k - 1) / 3];
      expRes = (own == 0) ? 9'h007 : 9'h00C;
      checkOutput($sformatf("tie%0d.gnt", k), {30'd0, bus.gnt1, bus.gnt0},
                  (own == 0) ? 32'd1 : 32'd2);
      checkOutput($sformatf("tie%0d.done", k), {30'd0, bus.done1, bus.done0},
                  (k % 3 != 0) ? 32'd0 : ((own == 0) ? 32'd1 : 32'd2));
      if (k % 3 != 1) begin
        checkOutput($sformatf("tie%0d.result", k), {23'd0, bus.result}, {23'd0, expRes});
      end
    end
    applyStimulus(0, 1'b0, 2'b00, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    checkOutput("tie.idle", {31'd0, bus.busy}, 32'd0);
    checkOutput("tie.gnt_off", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
